// File: rtl/buffer_sequencer.sv
// buffer_sequencer: paced write-side controller for the conv window shift buffer
module buffer_sequencer #(
  parameter int SIZE = 8,
  parameter int CYCLE = 8,
  parameter int BITi = 16,
  localparam int BITc = $clog2(SIZE),
  localparam int BITa = $clog2(CYCLE + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   terminate,
  input  logic                   in_valid,
  input  logic signed [BITi-1:0] in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [BITc-1:0]        wr_addr,
  output logic signed [BITi-1:0] wr_data,
  output logic [BITc:0]          fill,
  output logic                   window_valid,
  input  logic                   window_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted
);
  typedef enum logic [2:0] {IDLE, FILL, GAP, SETTLE, PRESENT} state_t;
  state_t state, state_nxt;
  logic [BITa-1:0] gap;
  logic accept, last, handshake, abort;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? FILL : IDLE;
      FILL:    state_nxt = !accept ? FILL : last ? SETTLE : (CYCLE > 1) ? GAP : FILL;
      GAP:     state_nxt = (gap == BITa'(1)) ? FILL : GAP;
      SETTLE:  state_nxt = PRESENT;
      PRESENT: state_nxt = !window_ready ? PRESENT : start ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end
  always_comb begin
    abort = terminate && state != IDLE;
    in_ready = state == FILL && !terminate;
    accept = in_valid && in_ready;
    last = fill == (BITc+1)'(SIZE - 1);
    handshake = state == PRESENT && window_ready;
    busy = state != IDLE;
  end
  // accept implies !terminate, so the clear and increment paths never collide
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      gap <= '0;
      fill <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      window_valid <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= fill[BITc-1:0];
        wr_data <= in_data;
      end
      fill <= (abort || handshake || (state == IDLE && start)) ? '0 : accept ? fill + 1'b1 : fill;
      gap <= abort ? '0 : (accept && !last) ? BITa'(CYCLE - 1) : (state == GAP) ? gap - 1'b1 : gap;
      window_valid <= state_nxt == PRESENT;
      done <= handshake && !abort;
      aborted <= abort;
    end
endmodule

// File: tb/tb_buffer_sequencer.sv
// tb_buffer_sequencer: directed scenarios plus a randomized run against a timing-level reference model
module tb_buffer_sequencer;
  localparam int SIZE = 8, CYCLE = 8, BITi = 16;
  logic clock = 0, reset = 1;
  logic start, terminate, in_valid, window_ready;
  logic [BITi-1:0] in_data, wr_data;
  logic in_ready, wr_en, window_valid, busy, done, aborted;
  logic [2:0] wr_addr;
  logic [3:0] fill;
  logic start1, terminate1, in_valid1, window_ready1;
  logic [BITi-1:0] in_data1, wr_data1;
  logic in_ready1, wr_en1, window_valid1, busy1, done1, aborted1;
  logic [2:0] wr_addr1;
  logic [3:0] fill1;
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  buffer_sequencer #(.SIZE(SIZE), .CYCLE(CYCLE), .BITi(BITi)) u8 (
    .clock(clock), .reset(reset), .start(start), .terminate(terminate),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .fill(fill), .window_valid(window_valid),
    .window_ready(window_ready), .busy(busy), .done(done), .aborted(aborted));

  buffer_sequencer #(.SIZE(SIZE), .CYCLE(1), .BITi(BITi)) u1 (
    .clock(clock), .reset(reset), .start(start1), .terminate(terminate1),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1), .wr_en(wr_en1),
    .wr_addr(wr_addr1), .wr_data(wr_data1), .fill(fill1), .window_valid(window_valid1),
    .window_ready(window_ready1), .busy(busy1), .done(done1), .aborted(aborted1));

  task automatic do_reset;
    reset = 1;
    {start, terminate, in_valid, window_ready, in_data} = '0;
    {start1, terminate1, in_valid1, window_ready1, in_data1} = '0;
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset;
    logic [28:0] o;
    do_reset;
    o = {in_ready, wr_en, wr_addr, wr_data, fill, window_valid, busy, done, aborted};
    total++;
    if (o !== '0) begin bad++; $display("FAIL reset_state: outputs=%h required 0", o); end
    start = 1;
    @(negedge clock);
    start = 0; in_valid = 1; in_data = 16'h0abc;
    for (int i = 0; i < 100 && fill !== 4'd3; i++) @(negedge clock);
    total++;
    if (fill !== 4'd3) begin bad++; $display("FAIL reset_reach_fill3: fill=%0d required 3", fill); end
    #2 reset = 1;
    #1;
    o = {in_ready, wr_en, wr_addr, wr_data, fill, window_valid, busy, done, aborted};
    total++;
    if (o !== '0) begin bad++; $display("FAIL reset_async: outputs=%h required 0", o); end
    @(negedge clock);
    reset = 0; in_valid = 0; start = 1;
    @(negedge clock);
    start = 0; in_valid = 1; in_data = 16'h1234;
    @(negedge clock);
    in_valid = 0;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 3'd0 || wr_data !== 16'h1234)
      begin bad++; $display("FAIL reset_restart: we=%b addr=%0d data=%h required 1 0 1234", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_full_window;
    logic [BITi-1:0] d [0:63];
    logic erdy, ewe, ewv;
    int efill;
    do_reset;
    start = 1;
    @(negedge clock);
    start = 0; in_valid = 1;
    for (int i = 0; i < 60; i++) begin
      d[i] = BITi'($urandom);
      in_data = d[i];
      #1;
      erdy = i <= 56 && i % 8 == 0;
      ewe = i >= 1 && i <= 57 && (i - 1) % 8 == 0;
      ewv = i >= 58;
      efill = (i == 0) ? 0 : ((i - 1) / 8 + 1 > 8 ? 8 : (i - 1) / 8 + 1);
      total++;
      if (in_ready !== erdy || wr_en !== ewe || window_valid !== ewv || fill !== efill ||
          (ewe && (wr_addr !== 3'((i - 1) / 8) || wr_data !== d[i - 1])))
        begin bad++; $display("FAIL window cyc=%0d rdy=%b/%b we=%b/%b wv=%b/%b fill=%0d/%0d addr=%0d data=%h", i, in_ready, erdy, wr_en, ewe, window_valid, ewv, fill, efill, wr_addr, wr_data); end
      @(negedge clock);
    end
    window_ready = 1;
    @(negedge clock);
    window_ready = 0;
    total++;
    if (done !== 1'b1 || window_valid !== 1'b0 || busy !== 1'b0 || fill !== 4'd0)
      begin bad++; $display("FAIL window_done: done=%b wv=%b busy=%b fill=%0d required 1 0 0 0", done, window_valid, busy, fill); end
    @(negedge clock);
    total++;
    if (done !== 1'b0 || wr_en !== 1'b0)
      begin bad++; $display("FAIL window_done_once: done=%b we=%b required 0 0", done, wr_en); end
  endtask

  task automatic test_restart;
    do_reset;
    start = 1;
    @(negedge clock);
    start = 0; in_valid = 1;
    for (int i = 0; i < 100 && window_valid !== 1'b1; i++) @(negedge clock);
    total++;
    if (window_valid !== 1'b1) begin bad++; $display("FAIL restart_window: wv=%b required 1", window_valid); end
    window_ready = 1; start = 1; in_data = 16'h5a5a;
    @(negedge clock);
    window_ready = 0; start = 0;
    #1;
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || fill !== 4'd0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL restart_handshake: done=%b busy=%b fill=%0d rdy=%b required 1 1 0 1", done, busy, fill, in_ready); end
    @(negedge clock);
    in_valid = 0;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 3'd0 || wr_data !== 16'h5a5a || fill !== 4'd1 || done !== 1'b0)
      begin bad++; $display("FAIL restart_first: we=%b addr=%0d data=%h fill=%0d done=%b required 1 0 5a5a 1 0", wr_en, wr_addr, wr_data, fill, done); end
  endtask

  task automatic test_irregular;
    logic [BITi-1:0] last_d;
    last_d = '0;
    do_reset;
    start = 1;
    @(negedge clock);
    start = 0;
    for (int p = 0; p < SIZE; p++) begin
      int g = $urandom_range(9, 14);
      for (int j = 0; j < g; j++) begin
        in_valid = (j == g - 1);
        in_data = BITi'($urandom);
        #1;
        total++;
        if (in_ready !== (p == 0 || j >= 7) || wr_en !== (p > 0 && j == 0) || fill !== p ||
            (p > 0 && j == 0 && (wr_addr !== 3'(p - 1) || wr_data !== last_d)))
          begin bad++; $display("FAIL irregular p=%0d j=%0d rdy=%b we=%b fill=%0d addr=%0d data=%h required fill %0d", p, j, in_ready, wr_en, fill, wr_addr, wr_data, p); end
        if (j == g - 1) last_d = in_data;
        @(negedge clock);
      end
    end
    in_valid = 0;
    #1;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 3'd7 || wr_data !== last_d || fill !== 4'd8 || in_ready !== 1'b0)
      begin bad++; $display("FAIL irregular_last: we=%b addr=%0d data=%h fill=%0d rdy=%b required 1 7 %h 8 0", wr_en, wr_addr, wr_data, fill, in_ready, last_d); end
  endtask

  task automatic test_terminate;
    do_reset;
    start = 1;
    @(negedge clock);
    start = 0; in_valid = 1;
    for (int i = 0; i < 100 && !(fill === 4'd5 && in_ready === 1'b1); i++) @(negedge clock);
    total++;
    if (fill !== 4'd5 || in_ready !== 1'b1) begin bad++; $display("FAIL term_reach: fill=%0d rdy=%b required 5 1", fill, in_ready); end
    terminate = 1; in_data = 16'h7777;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL term_ready_gate: rdy=%b required 0", in_ready); end
    @(negedge clock);
    terminate = 0;
    total++;
    if (wr_en !== 1'b0 || aborted !== 1'b1 || fill !== 4'd0 || busy !== 1'b0 || window_valid !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL term_abort: we=%b ab=%b fill=%0d busy=%b wv=%b done=%b required 0 1 0 0 0 0", wr_en, aborted, fill, busy, window_valid, done); end
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      total++;
      if (window_valid !== 1'b0 || wr_en !== 1'b0 || aborted !== 1'b0)
        begin bad++; $display("FAIL term_quiet cyc=%0d: wv=%b we=%b ab=%b required 0 0 0", i, window_valid, wr_en, aborted); end
    end
    terminate = 1;
    @(negedge clock);
    terminate = 0;
    total++;
    if (aborted !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL term_idle: ab=%b busy=%b required 0 0", aborted, busy); end
    start = 1;
    @(negedge clock);
    start = 0;
    @(negedge clock);
    terminate = 1;
    #1;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 3'd0) begin bad++; $display("FAIL term_sched_write: we=%b addr=%0d required 1 0", wr_en, wr_addr); end
    @(negedge clock);
    terminate = 0; in_valid = 0;
    total++;
    if (aborted !== 1'b1 || wr_en !== 1'b0) begin bad++; $display("FAIL term_after_write: ab=%b we=%b required 1 0", aborted, wr_en); end
  endtask

  task automatic test_cycle1;
    logic [BITi-1:0] d [0:15];
    do_reset;
    start1 = 1;
    @(negedge clock);
    start1 = 0; in_valid1 = 1;
    for (int i = 0; i < 10; i++) begin
      d[i] = BITi'($urandom);
      in_data1 = d[i];
      #1;
      total++;
      if (in_ready1 !== (i < 8) || wr_en1 !== (i >= 1 && i <= 8) || window_valid1 !== (i >= 9) ||
          (i >= 1 && i <= 8 && (wr_addr1 !== 3'(i - 1) || wr_data1 !== d[i - 1])))
        begin bad++; $display("FAIL cycle1 cyc=%0d rdy=%b we=%b wv=%b addr=%0d data=%h", i, in_ready1, wr_en1, window_valid1, wr_addr1, wr_data1); end
      @(negedge clock);
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      total++;
      if (window_valid1 !== 1'b1 || in_ready1 !== 1'b0 || done1 !== 1'b0 || fill1 !== 4'd8 || busy1 !== 1'b1 || aborted1 !== 1'b0)
        begin bad++; $display("FAIL cycle1_hold cyc=%0d: wv=%b rdy=%b done=%b fill=%0d busy=%b ab=%b", i, window_valid1, in_ready1, done1, fill1, busy1, aborted1); end
      @(negedge clock);
    end
    window_ready1 = 1; in_valid1 = 0;
    @(negedge clock);
    window_ready1 = 0;
    total++;
    if (done1 !== 1'b1 || window_valid1 !== 1'b0 || busy1 !== 1'b0 || aborted1 !== 1'b0)
      begin bad++; $display("FAIL cycle1_done: done=%b wv=%b busy=%b ab=%b required 1 0 0 0", done1, window_valid1, busy1, aborted1); end
  endtask

  // Model tracks phases and the earliest cycle the next sample may be taken
  task automatic test_random;
    int mode, mfill, next_ok, win_at;
    logic ewe, edone, eab, erdy, ewv, acc;
    logic [2:0] eaddr;
    logic [BITi-1:0] edata;
    do_reset;
    mode = 0; mfill = 0; next_ok = 0; win_at = 0;
    ewe = 0; edone = 0; eab = 0; eaddr = '0; edata = '0;
    for (int n = 0; n < 3000; n++) begin
      start = $urandom_range(0, 3) == 0;
      terminate = $urandom_range(0, 150) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      window_ready = $urandom_range(0, 3) == 0;
      in_data = BITi'($urandom);
      #1;
      erdy = mode == 1 && n >= next_ok && !terminate;
      ewv = mode == 2 && n >= win_at;
      total++;
      if (in_ready !== erdy || wr_en !== ewe || (ewe && (wr_addr !== eaddr || wr_data !== edata)) ||
          fill !== mfill || window_valid !== ewv || busy !== (mode != 0) || done !== edone || aborted !== eab)
        begin bad++; $display("FAIL random n=%0d rdy=%b/%b we=%b/%b addr=%0d/%0d fill=%0d/%0d wv=%b/%b busy=%b done=%b/%b ab=%b/%b", n, in_ready, erdy, wr_en, ewe, wr_addr, eaddr, fill, mfill, window_valid, ewv, busy, done, edone, aborted, eab); end
      acc = erdy && in_valid;
      ewe = acc;
      if (acc) begin eaddr = 3'(mfill); edata = in_data; end
      edone = 0; eab = 0;
      if (terminate && mode != 0) begin
        mode = 0; mfill = 0; eab = 1;
      end else if (mode == 0) begin
        if (start) begin mode = 1; mfill = 0; next_ok = n + 1; end
      end else if (mode == 1) begin
        if (acc) begin
          mfill++;
          next_ok = n + CYCLE;
          if (mfill == SIZE) begin mode = 2; win_at = n + 2; end
        end
      end else if (ewv && window_ready) begin
        edone = 1; mfill = 0; mode = start ? 1 : 0; next_ok = n + 1;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset;
    test_full_window;
    test_restart;
    test_irregular;
    test_terminate;
    test_cycle1;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
